// File: rtl/fib_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the FIB lookup controller, the level memories
// and the bench: controller states, root pointer and the result record.
package fib_pkg;

  localparam int WORD_SIZE_DEF    = 16;
  localparam int POINTER_SIZE_DEF = 16;
  localparam int MAX_LEVELS_DEF   = 8;
  localparam int LVL_W_DEF        = $clog2(MAX_LEVELS_DEF + 1);

  // Every name walk starts at the root node of level 1.
  localparam int ROOT_PTR = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EVAL  = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DRAIN = 3'd5,
    ST_DONE  = 3'd6
  } fib_state_e;

  // Longest-prefix record returned once per name.
  typedef struct packed {
    logic                        match;
    logic [LVL_W_DEF-1:0]        level;
    logic [POINTER_SIZE_DEF-1:0] pointer;
  } fib_result_t;

endpackage

// File: rtl/fib_lookup_ctrl.sv
`timescale 1ns/1ps
// FIB lookup initiator: walks the level memories one name component at a
// time from the root pointer, records the deepest match and returns one
// result per name. Components past MAX_LEVELS, or after a miss or a leaf,
// are drained without further level requests.
//
// Handshakes: a component beat transfers on a rising edge where
// comp_valid_in and comp_ready_out are both 1; a result transfers on a
// rising edge where result_valid_out and result_ready_in are both 1.
// Valid never depends on ready, and result_valid_out stays high with
// stable result fields until it transfers.
module fib_lookup_ctrl
  import fib_pkg::*;
#(
  parameter int WORD_SIZE     = 16,
  parameter int POINTER_SIZE  = 16,
  parameter int MAX_LEVELS    = 8,
  parameter int LEVEL_LATENCY = 1,
  parameter int LVL_W         = $clog2(MAX_LEVELS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    comp_valid_in,
  output logic                    comp_ready_out,
  input  logic [WORD_SIZE-1:0]    comp_data_in,
  input  logic                    comp_last_in,
  output logic                    lvl_req_out,
  output logic [LVL_W-1:0]        lvl_sel_out,
  output logic [POINTER_SIZE-1:0] address_out,
  output logic [WORD_SIZE-1:0]    lookup_cont_out,
  input  logic [POINTER_SIZE-1:0] next_pointer_in,
  input  logic                    is_match_in,
  input  logic                    no_child_in,
  output logic                    result_valid_out,
  input  logic                    result_ready_in,
  output logic                    result_match_out,
  output logic [LVL_W-1:0]        result_level_out,
  output logic [POINTER_SIZE-1:0] result_pointer_out,
  output fib_state_e              dbg_state_out
);

  // The WAIT state covers LEVEL_LATENCY-1 cycles; with latency 1 the
  // response is already valid in the cycle after ISSUE and WAIT is skipped.
  localparam int CNT_W     = (LEVEL_LATENCY > 2) ? $clog2(LEVEL_LATENCY) : 1;
  localparam int WAIT_LOAD = (LEVEL_LATENCY > 1) ? LEVEL_LATENCY - 2 : 0;

  fib_state_e              state_q, state_d;
  logic                    last_q;
  logic [POINTER_SIZE-1:0] ptr_q;
  logic [LVL_W-1:0]        lvl_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [LVL_W-1:0]        sel_q;
  logic [POINTER_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0]    cont_q;
  logic                    res_valid_q;
  logic                    res_match_q;
  logic [LVL_W-1:0]        res_level_q;
  logic [POINTER_SIZE-1:0] res_ptr_q;

  logic lvl_at_max;
  logic eval_term;

  assign lvl_at_max = (lvl_q == LVL_W'(MAX_LEVELS));
  // A walk ends on a miss, at a leaf, on the final component, or once the
  // deepest level has been consulted.
  assign eval_term  = !is_match_in || no_child_in || last_q || lvl_at_max;

  assign lvl_sel_out        = sel_q;
  assign address_out        = addr_q;
  assign lookup_cont_out    = cont_q;
  assign result_valid_out   = res_valid_q;
  assign result_match_out   = res_match_q;
  assign result_level_out   = res_level_q;
  assign result_pointer_out = res_ptr_q;
  assign dbg_state_out      = state_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode plus the state-decoded strobes comp_ready and lvl_req.
  always_comb begin
    state_d        = state_q;
    comp_ready_out = 1'b0;
    lvl_req_out    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        comp_ready_out = 1'b1;
        if (comp_valid_in) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        lvl_req_out = 1'b1;
        state_d     = (LEVEL_LATENCY > 1) ? ST_WAIT : ST_EVAL;
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        if (eval_term) state_d = last_q ? ST_DONE : ST_DRAIN;
        else           state_d = ST_NEXT;
      end
      ST_NEXT: begin
        comp_ready_out = 1'b1;
        if (comp_valid_in) state_d = ST_ISSUE;
      end
      ST_DRAIN: begin
        comp_ready_out = 1'b1;
        if (comp_valid_in && comp_last_in) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (result_ready_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Walk datapath: request fields are loaded on entry to ISSUE, the match
  // record and walk position are updated in EVAL only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= 1'b0;
      ptr_q       <= '0;
      lvl_q       <= '0;
      cnt_q       <= '0;
      sel_q       <= '0;
      addr_q      <= '0;
      cont_q      <= '0;
      res_valid_q <= 1'b0;
      res_match_q <= 1'b0;
      res_level_q <= '0;
      res_ptr_q   <= '0;
    end else begin
      res_valid_q <= (state_d == ST_DONE);
      case (state_q)
        ST_IDLE: begin
          if (comp_valid_in) begin
            last_q      <= comp_last_in;
            ptr_q       <= POINTER_SIZE'(ROOT_PTR);
            lvl_q       <= LVL_W'(1);
            res_match_q <= 1'b0;
            res_level_q <= '0;
            res_ptr_q   <= '0;
            sel_q       <= LVL_W'(1);
            addr_q      <= POINTER_SIZE'(ROOT_PTR);
            cont_q      <= comp_data_in;
          end
        end
        ST_ISSUE: begin
          cnt_q <= CNT_W'(WAIT_LOAD);
        end
        ST_WAIT: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        end
        ST_EVAL: begin
          if (is_match_in) begin
            res_match_q <= 1'b1;
            res_level_q <= lvl_q;
            res_ptr_q   <= next_pointer_in;
            ptr_q       <= next_pointer_in;
            if (!lvl_at_max) lvl_q <= lvl_q + LVL_W'(1);
          end
        end
        ST_NEXT: begin
          if (comp_valid_in) begin
            last_q <= comp_last_in;
            sel_q  <= lvl_q;
            addr_q <= ptr_q;
            cont_q <= comp_data_in;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_lookup_ctrl.sv
`timescale 1ns/1ps
module tb_fib_lookup_ctrl;
  import fib_pkg::*;

  localparam int WS  = 16;
  localparam int PS  = 16;
  localparam int ML  = 8;
  localparam int LAT = 2;
  localparam int LW  = $clog2(ML + 1);

  logic          clk;
  logic          rst_n;
  logic          comp_valid_in;
  logic          comp_ready_out;
  logic [WS-1:0] comp_data_in;
  logic          comp_last_in;
  logic          lvl_req_out;
  logic [LW-1:0] lvl_sel_out;
  logic [PS-1:0] address_out;
  logic [WS-1:0] lookup_cont_out;
  logic [PS-1:0] next_pointer_in;
  logic          is_match_in;
  logic          no_child_in;
  logic          result_valid_out;
  logic          result_ready_in;
  logic          result_match_out;
  logic [LW-1:0] result_level_out;
  logic [PS-1:0] result_pointer_out;
  fib_state_e    dbg_state_out;

  // Level memory model: per-level response table selected by lvl_sel.
  logic          resp_match   [0:15];
  logic          resp_nochild [0:15];
  logic [PS-1:0] resp_ptr     [0:15];

  assign is_match_in     = resp_match[lvl_sel_out];
  assign no_child_in     = resp_nochild[lvl_sel_out];
  assign next_pointer_in = resp_ptr[lvl_sel_out];

  int n_cmp  = 0;
  int n_fail = 0;

  logic [PS-1:0] exp_q[$];
  logic [LW-1:0] req_sel_q[$];
  logic [PS-1:0] req_addr_q[$];
  logic [WS-1:0] req_cont_q[$];

  fib_lookup_ctrl #(
    .WORD_SIZE(WS), .POINTER_SIZE(PS), .MAX_LEVELS(ML), .LEVEL_LATENCY(LAT), .LVL_W(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .comp_valid_in(comp_valid_in), .comp_ready_out(comp_ready_out),
    .comp_data_in(comp_data_in), .comp_last_in(comp_last_in),
    .lvl_req_out(lvl_req_out), .lvl_sel_out(lvl_sel_out),
    .address_out(address_out), .lookup_cont_out(lookup_cont_out),
    .next_pointer_in(next_pointer_in), .is_match_in(is_match_in),
    .no_child_in(no_child_in),
    .result_valid_out(result_valid_out), .result_ready_in(result_ready_in),
    .result_match_out(result_match_out), .result_level_out(result_level_out),
    .result_pointer_out(result_pointer_out), .dbg_state_out(dbg_state_out)
  );

  // Clock and request monitor.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && lvl_req_out) begin
      req_sel_q.push_back(lvl_sel_out);
      req_addr_q.push_back(address_out);
      req_cont_q.push_back(lookup_cont_out);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_reqs();
    req_sel_q.delete();
    req_addr_q.delete();
    req_cont_q.delete();
    exp_q.delete();
  endtask

  task automatic clear_table();
    for (int l = 0; l < 16; l++) begin
      resp_match[l]   = 1'b0;
      resp_nochild[l] = 1'b0;
      resp_ptr[l]     = '0;
    end
  endtask

  task automatic set_level(input int l, input logic m, input logic nc, input logic [PS-1:0] p);
    resp_match[l]   = m;
    resp_nochild[l] = nc;
    resp_ptr[l]     = p;
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    comp_valid_in   = 1'b0;
    comp_data_in    = '0;
    comp_last_in    = 1'b0;
    result_ready_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_reqs();
  endtask

  // Called at a negedge; returns at the negedge after the beat transfers.
  task automatic send_beat(input logic [WS-1:0] d, input logic last);
    int n;
    n = 0;
    comp_valid_in = 1'b1;
    comp_data_in  = d;
    comp_last_in  = last;
    while (!comp_ready_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (comp_ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL beat_accept: comp_ready=%b required 1 (data %h)", comp_ready_out, d);
    end
    @(negedge clk);
    comp_valid_in = 1'b0;
    comp_last_in  = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!result_valid_out && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic ack_result();
    result_ready_in = 1'b1;
    @(negedge clk);
    result_ready_in = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({comp_ready_out, lvl_req_out} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_strobes: ready,req=%b required 10", {comp_ready_out, lvl_req_out});
    end
    n_cmp++;
    if ({lvl_sel_out, address_out, lookup_cont_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_request: sel=%0d addr=%h cont=%h required 0", lvl_sel_out, address_out, lookup_cont_out);
    end
    n_cmp++;
    if ({result_valid_out, result_match_out, result_level_out, result_pointer_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_result: v=%b m=%b l=%0d p=%h required 0", result_valid_out, result_match_out, result_level_out, result_pointer_out);
    end
    n_cmp++;
    if (dbg_state_out !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d required %0d", dbg_state_out, ST_IDLE);
    end
  endtask

  task automatic test_single();
    int lat;
    clear_table();
    clear_reqs();
    set_level(1, 1'b1, 1'b1, 16'h0005);
    send_beat(16'h7b7d, 1'b1);
    wait_valid(lat);
    n_cmp++;
    if (lat != LAT + 1) begin
      n_fail++;
      $display("FAIL single_latency: cycles=%0d required %0d", lat, LAT + 1);
    end
    n_cmp++;
    if ({result_valid_out, result_match_out, result_level_out, result_pointer_out} !== {1'b1, 1'b1, 4'd1, 16'h0005}) begin
      n_fail++;
      $display("FAIL single_result: v=%b m=%b l=%0d p=%h required 1 1 1 0005", result_valid_out, result_match_out, result_level_out, result_pointer_out);
    end
    ack_result();
    n_cmp++;
    if (req_sel_q.size() != 1) begin
      n_fail++;
      $display("FAIL single_req_count: reqs=%0d required 1", req_sel_q.size());
    end else begin
      n_cmp++;
      if ({req_sel_q[0], req_addr_q[0], req_cont_q[0]} !== {4'd1, 16'h0000, 16'h7b7d}) begin
        n_fail++;
        $display("FAIL single_req: sel=%0d addr=%h cont=%h required 1 0000 7b7d", req_sel_q[0], req_addr_q[0], req_cont_q[0]);
      end
    end
  endtask

  task automatic test_two_levels();
    int lat;
    clear_table();
    clear_reqs();
    set_level(1, 1'b1, 1'b0, 16'h0001);
    set_level(2, 1'b1, 1'b1, 16'h0009);
    send_beat(16'h2121, 1'b0);
    send_beat(16'h5c6c, 1'b1);
    wait_valid(lat);
    n_cmp++;
    if ({result_valid_out, result_match_out, result_level_out, result_pointer_out} !== {1'b1, 1'b1, 4'd2, 16'h0009}) begin
      n_fail++;
      $display("FAIL two_result: v=%b m=%b l=%0d p=%h required 1 1 2 0009", result_valid_out, result_match_out, result_level_out, result_pointer_out);
    end
    ack_result();
    n_cmp++;
    if (req_sel_q.size() != 2) begin
      n_fail++;
      $display("FAIL two_req_count: reqs=%0d required 2", req_sel_q.size());
    end else begin
      n_cmp++;
      if ({req_sel_q[1], req_addr_q[1], req_cont_q[1]} !== {4'd2, 16'h0001, 16'h5c6c}) begin
        n_fail++;
        $display("FAIL two_req2: sel=%0d addr=%h cont=%h required 2 0001 5c6c", req_sel_q[1], req_addr_q[1], req_cont_q[1]);
      end
    end
  endtask

  task automatic test_miss_drain();
    int lat;
    clear_table();
    clear_reqs();
    set_level(1, 1'b1, 1'b0, 16'h0003);
    set_level(2, 1'b0, 1'b0, 16'h00ee);
    send_beat(16'h6162, 1'b0);
    send_beat(16'h6364, 1'b0);
    send_beat(16'h6566, 1'b1);
    wait_valid(lat);
    n_cmp++;
    if ({result_valid_out, result_match_out, result_level_out, result_pointer_out} !== {1'b1, 1'b1, 4'd1, 16'h0003}) begin
      n_fail++;
      $display("FAIL drain_result: v=%b m=%b l=%0d p=%h required 1 1 1 0003", result_valid_out, result_match_out, result_level_out, result_pointer_out);
    end
    ack_result();
    n_cmp++;
    if (req_sel_q.size() != 2) begin
      n_fail++;
      $display("FAIL drain_req_count: reqs=%0d required 2", req_sel_q.size());
    end
  endtask

  task automatic test_first_miss();
    int lat;
    clear_table();
    clear_reqs();
    send_beat(16'h7a7a, 1'b1);
    wait_valid(lat);
    n_cmp++;
    if ({result_valid_out, result_match_out, result_level_out, result_pointer_out} !== {1'b1, 1'b0, 4'd0, 16'h0000}) begin
      n_fail++;
      $display("FAIL miss_result: v=%b m=%b l=%0d p=%h required 1 0 0 0000", result_valid_out, result_match_out, result_level_out, result_pointer_out);
    end
    ack_result();
    n_cmp++;
    if (req_sel_q.size() != 1) begin
      n_fail++;
      $display("FAIL miss_req_count: reqs=%0d required 1", req_sel_q.size());
    end
  endtask

  task automatic test_max_levels();
    int lat;
    logic [PS-1:0] ea;
    clear_table();
    clear_reqs();
    for (int l = 1; l <= ML; l++) begin
      set_level(l, 1'b1, 1'b0, 16'h0100 + 16'(l));
      exp_q.push_back((l == 1) ? 16'h0000 : 16'h0100 + 16'(l - 1));
    end
    for (int i = 1; i <= ML + 2; i++) send_beat(16'h4100 + 16'(i), (i == ML + 2));
    wait_valid(lat);
    n_cmp++;
    if ({result_valid_out, result_match_out, result_level_out, result_pointer_out} !== {1'b1, 1'b1, 4'd8, 16'h0108}) begin
      n_fail++;
      $display("FAIL max_result: v=%b m=%b l=%0d p=%h required 1 1 8 0108", result_valid_out, result_match_out, result_level_out, result_pointer_out);
    end
    ack_result();
    n_cmp++;
    if (req_sel_q.size() != ML) begin
      n_fail++;
      $display("FAIL max_req_count: reqs=%0d required %0d", req_sel_q.size(), ML);
    end else begin
      for (int i = 0; i < ML; i++) begin
        ea = exp_q.pop_front();
        n_cmp++;
        if ({req_sel_q[i], req_addr_q[i]} !== {LW'(i + 1), ea}) begin
          n_fail++;
          $display("FAIL max_req%0d: sel=%0d addr=%h required %0d %h", i + 1, req_sel_q[i], req_addr_q[i], i + 1, ea);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    clear_table();
    clear_reqs();
    set_level(1, 1'b1, 1'b0, 16'h0011);
    send_beat(16'h3031, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (dbg_state_out !== ST_WAIT) begin
      n_fail++;
      $display("FAIL midrst_in_wait: state=%0d required %0d", dbg_state_out, ST_WAIT);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({comp_ready_out, lvl_req_out, lvl_sel_out, address_out, lookup_cont_out} !== {2'b10, 4'd0, 16'h0, 16'h0}) begin
      n_fail++;
      $display("FAIL midrst_outputs: ready=%b req=%b sel=%0d addr=%h cont=%h required 1 0 0 0000 0000", comp_ready_out, lvl_req_out, lvl_sel_out, address_out, lookup_cont_out);
    end
    n_cmp++;
    if ({result_valid_out, result_match_out, result_level_out, result_pointer_out} !== '0) begin
      n_fail++;
      $display("FAIL midrst_result: v=%b m=%b l=%0d p=%h required 0", result_valid_out, result_match_out, result_level_out, result_pointer_out);
    end
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    clear_reqs();
    set_level(1, 1'b1, 1'b1, 16'h0042);
    send_beat(16'h3233, 1'b1);
    wait_valid(lat);
    n_cmp++;
    if ({result_valid_out, result_match_out, result_level_out, result_pointer_out} !== {1'b1, 1'b1, 4'd1, 16'h0042}) begin
      n_fail++;
      $display("FAIL midrst_next_name: v=%b m=%b l=%0d p=%h required 1 1 1 0042", result_valid_out, result_match_out, result_level_out, result_pointer_out);
    end
    ack_result();
  endtask

  task automatic test_result_hold();
    int lat;
    clear_table();
    clear_reqs();
    set_level(1, 1'b1, 1'b0, 16'h0021);
    set_level(2, 1'b1, 1'b1, 16'h0077);
    send_beat(16'h5859, 1'b0);
    send_beat(16'h5a5b, 1'b1);
    wait_valid(lat);
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if ({result_valid_out, result_match_out, result_level_out, result_pointer_out, comp_ready_out} !== {1'b1, 1'b1, 4'd2, 16'h0077, 1'b0}) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: v=%b m=%b l=%0d p=%h ready=%b required 1 1 2 0077 0", c, result_valid_out, result_match_out, result_level_out, result_pointer_out, comp_ready_out);
      end
      @(negedge clk);
    end
    ack_result();
    n_cmp++;
    if ({comp_ready_out, result_valid_out} !== 2'b10) begin
      n_fail++;
      $display("FAIL hold_release: ready=%b valid=%b required 1 0", comp_ready_out, result_valid_out);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_table();
    test_reset();
    test_single();
    test_two_levels();
    test_miss_drain();
    test_first_miss();
    test_max_levels();
    test_reset_mid();
    test_result_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
